// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel strobe, x/y counts, video_on, hsync/vsync, frame_start.
// Optional 1 Hz frame tick is compiled in with VGA_BLINK_TICK_EN.
module vga_sync_gen #(
   parameter int unsigned H_DISPLAY = 800,
   parameter int unsigned H_FP      = 56,
   parameter int unsigned H_SYNC    = 120,
   parameter int unsigned H_BP      = 64,
   parameter int unsigned V_DISPLAY = 600,
   parameter int unsigned V_FP      = 37,
   parameter int unsigned V_SYNC    = 6,
   parameter int unsigned V_BP      = 23,
   parameter bit          SYNC_POL  = 1'b1,
   parameter int unsigned CLK_DIV   = 2
`ifdef VGA_BLINK_TICK_EN
   ,
   parameter int unsigned FRAMES_PER_SEC = 72
`endif
) (
   input  logic        clk,
   input  logic        reset,
   output logic        p_tick,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
`ifdef VGA_BLINK_TICK_EN
   ,
   output logic        tick_1Hz
`endif
);

   localparam int unsigned CNT_W    = 11;
   localparam int unsigned DIV_W    = 4;
   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_DISPLAY + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_DISPLAY + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be in 1..16");
   end

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_nxt_c;
   logic [CNT_W-1:0] x_nxt_c;
   logic [CNT_W-1:0] y_nxt_c;
   logic             start_c;

   // Next-state counts; flags below are decoded from these so they register with x/y
   always_comb begin
      div_nxt_c = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
      x_nxt_c   = x;
      y_nxt_c   = y;
      if (p_tick) begin
         if (x == CNT_W'(H_TOTAL - 1)) begin
            x_nxt_c = '0;
            y_nxt_c = (y == CNT_W'(V_TOTAL - 1)) ? '0 : y + CNT_W'(1);
         end else begin
            x_nxt_c = x + CNT_W'(1);
         end
      end
      start_c = p_tick && (x_nxt_c == '0) && (y_nxt_c == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q       <= '0;
         p_tick      <= 1'b0;
         x           <= CNT_W'(H_TOTAL - 1);
         y           <= CNT_W'(V_TOTAL - 1);
         video_on    <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else begin
         div_q       <= div_nxt_c;
         p_tick      <= (div_nxt_c == DIV_W'(CLK_DIV - 1));
         x           <= x_nxt_c;
         y           <= y_nxt_c;
         video_on    <= (x_nxt_c < CNT_W'(H_DISPLAY)) && (y_nxt_c < CNT_W'(V_DISPLAY));
         hsync       <= ((x_nxt_c >= CNT_W'(HS_START)) && (x_nxt_c <= CNT_W'(HS_END))) ?
                        SYNC_POL : ~SYNC_POL;
         vsync       <= ((y_nxt_c >= CNT_W'(VS_START)) && (y_nxt_c <= CNT_W'(VS_END))) ?
                        SYNC_POL : ~SYNC_POL;
         frame_start <= start_c;
      end
   end

`ifdef VGA_BLINK_TICK_EN
   localparam int unsigned FC_W = 7;

   if (FRAMES_PER_SEC < 1 || FRAMES_PER_SEC > 128) begin : g_bad_fps
      $error("vga_sync_gen: FRAMES_PER_SEC must be in 1..128");
   end

   logic [FC_W-1:0] frame_cnt;

   // Frame counter wraps on the frame_start that emits the tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         tick_1Hz  <= 1'b0;
      end else begin
         tick_1Hz <= 1'b0;
         if (start_c) begin
            if (frame_cnt == FC_W'(FRAMES_PER_SEC - 1)) begin
               frame_cnt <= '0;
               tick_1Hz  <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + FC_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations checked every cycle against an arithmetic raster model.
module tb_vga_sync_gen;

   typedef struct packed {
      logic        p;
      logic [10:0] x;
      logic [10:0] y;
      logic        vo;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        tk;
   } tup_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n = 0;
   int seg = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int last_b = -1;
   int hs_cnt_a = 0;

   logic        a_p, b_p, c_p;
   logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic        a_vo, a_hs, a_vs, a_fs, a_tk;
   logic        b_vo, b_hs, b_vs, b_fs, b_tk;
   logic        c_vo, c_hs, c_vs, c_fs, c_tk;

   vga_sync_gen dut_a (
      .clk(clk), .reset(reset), .p_tick(a_p), .x(a_x), .y(a_y), .video_on(a_vo),
      .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
`ifdef VGA_BLINK_TICK_EN
      , .tick_1Hz(a_tk)
`endif
   );

   vga_sync_gen #(
      .H_DISPLAY(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISPLAY(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b1), .CLK_DIV(2)
`ifdef VGA_BLINK_TICK_EN
      , .FRAMES_PER_SEC(3)
`endif
   ) dut_b (
      .clk(clk), .reset(reset), .p_tick(b_p), .x(b_x), .y(b_y), .video_on(b_vo),
      .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
`ifdef VGA_BLINK_TICK_EN
      , .tick_1Hz(b_tk)
`endif
   );

   vga_sync_gen #(
      .H_DISPLAY(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0), .CLK_DIV(1)
`ifdef VGA_BLINK_TICK_EN
      , .FRAMES_PER_SEC(3)
`endif
   ) dut_c (
      .clk(clk), .reset(reset), .p_tick(c_p), .x(c_x), .y(c_y), .video_on(c_vo),
      .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs)
`ifdef VGA_BLINK_TICK_EN
      , .tick_1Hz(c_tk)
`endif
   );

`ifndef VGA_BLINK_TICK_EN
   assign a_tk = 1'b0;
   assign b_tk = 1'b0;
   assign c_tk = 1'b0;
`endif

   // Clock edges since the last reset release
   always @(posedge clk or posedge reset) begin
      if (reset) n <= 0;
      else       n <= n + 1;
   end

   // Expected outputs after n edges: count pixel steps, then place them on the raster
   function automatic tup_t model(input int nn, input int hd, input int hfp, input int hsw,
                                  input int hbp, input int vd, input int vfp, input int vsw,
                                  input int vbp, input int dv, input bit pol, input int fps);
      int ht, vt, fr, u, pos, px, py, frames;
      bit upd;
      tup_t t;
      ht = hd + hfp + hsw + hbp;
      vt = vd + vfp + vsw + vbp;
      fr = ht * vt;
      if (dv == 1) u = (nn > 1) ? nn - 1 : 0;
      else         u = nn / dv;
      pos = (u + fr - 1) % fr;
      px = pos % ht;
      py = pos / ht;
      t.p  = (nn > 0) && (nn % dv == dv - 1);
      t.x  = 11'(px);
      t.y  = 11'(py);
      t.vo = (px < hd) && (py < vd);
      t.hs = (px >= hd + hfp && px < hd + hfp + hsw) ? pol : !pol;
      t.vs = (py >= vd + vfp && py < vd + vfp + vsw) ? pol : !pol;
      upd  = (dv == 1) ? (nn >= 2) : (nn > 0 && nn % dv == 0);
      t.fs = upd && (pos == 0);
      frames = (u == 0) ? 0 : (u - 1) / fr + 1;
`ifdef VGA_BLINK_TICK_EN
      t.tk = t.fs && (frames % fps == 0);
`else
      t.tk = 1'b0 && (frames == fps);
`endif
      return t;
   endfunction

   task automatic chk(input string nm, input tup_t act, input tup_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s seg=%0d n=%0d: got p=%0b x=%0d y=%0d vo=%0b hs=%0b vs=%0b fs=%0b tk=%0b, want p=%0b x=%0d y=%0d vo=%0b hs=%0b vs=%0b fs=%0b tk=%0b",
                  nm, seg, n, act.p, act.x, act.y, act.vo, act.hs, act.vs, act.fs, act.tk,
                  exp.p, exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.fs, exp.tk);
      end
   endtask

   task automatic chk_val(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s seg=%0d n=%0d: got %0d, want %0d", nm, seg, n, act, exp);
      end
   endtask

   // Per-cycle comparison plus literal pins of the default raster
   always @(negedge clk) begin
      chk("dut_a", {a_p, a_x, a_y, a_vo, a_hs, a_vs, a_fs, a_tk},
          model(n, 800, 56, 120, 64, 600, 37, 6, 23, 2, 1'b1, 72));
      chk("dut_b", {b_p, b_x, b_y, b_vo, b_hs, b_vs, b_fs, b_tk},
          model(n, 10, 2, 3, 2, 5, 2, 2, 3, 2, 1'b1, 3));
      chk("dut_c", {c_p, c_x, c_y, c_vo, c_hs, c_vs, c_fs, c_tk},
          model(n, 8, 1, 2, 1, 4, 1, 1, 1, 1, 1'b0, 3));

      if (b_fs) begin
         if (last_b >= 0) chk_val("b_frame_gap", n - last_b, 408);
         last_b = n;
      end

      if (seg == 0) begin
         if (a_hs) hs_cnt_a++;
         case (n)
            1: begin
               chk_val("c_ptick_first", int'(c_p), 1);
               chk_val("c_x_first", int'(c_x), 11);
               chk_val("c_hs_idle", int'(c_hs), 1);
            end
            2: begin
               chk_val("a_x_origin", int'(a_x), 0);
               chk_val("a_y_origin", int'(a_y), 0);
               chk_val("a_vo_origin", int'(a_vo), 1);
               chk_val("a_fs_origin", int'(a_fs), 1);
               chk_val("a_hs_origin", int'(a_hs), 0);
               chk_val("c_fs_origin", int'(c_fs), 1);
            end
            3:    chk_val("a_fs_single", int'(a_fs), 0);
            1601: chk_val("a_vo_x799", int'(a_vo), 1);
            1602: chk_val("a_vo_x800", int'(a_vo), 0);
            1713: begin chk_val("a_x_855", int'(a_x), 855); chk_val("a_hs_855", int'(a_hs), 0); end
            1714: begin chk_val("a_x_856", int'(a_x), 856); chk_val("a_hs_856", int'(a_hs), 1); end
            1953: begin chk_val("a_x_975", int'(a_x), 975); chk_val("a_hs_975", int'(a_hs), 1); end
            1954: begin chk_val("a_x_976", int'(a_x), 976); chk_val("a_hs_976", int'(a_hs), 0); end
            2083: begin chk_val("a_x_wrap", int'(a_x), 0); chk_val("a_y_wrap", int'(a_y), 1); end
            2200: chk_val("a_hs_clk_count", hs_cnt_a, 240);
            default: ;
         endcase
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (5000) @(posedge clk);
      for (int s = 1; s <= 8; s++) begin
         repeat ($urandom_range(3000, 50)) @(posedge clk);
         #($urandom_range(3, 1));
         reset = 1'b1;
         last_b = -1;
         #1;
         chk_val("rst_a_x", int'(a_x), 1039);
         chk_val("rst_a_y", int'(a_y), 665);
         chk_val("rst_a_vo", int'(a_vo), 0);
         chk_val("rst_a_hs", int'(a_hs), 0);
         chk_val("rst_a_vs", int'(a_vs), 0);
         chk_val("rst_a_fs", int'(a_fs), 0);
         chk_val("rst_a_p", int'(a_p), 0);
         chk_val("rst_c_hs", int'(c_hs), 1);
         chk_val("rst_c_vs", int'(c_vs), 1);
         seg = s;
         repeat ($urandom_range(3, 1)) @(negedge clk);
         reset = 1'b0;
      end
      repeat (500) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that drives the pixel generators (clock/movement text overlay).
- Produces the pixel coordinates, the `video_on` blanking flag, and the `hsync`/`vsync` pins for 800x600@72 Hz from the 100 MHz board clock.
- It is the source end of the x/y/`video_on` interface that pixel generators consume.
- All outputs are registered and mutually aligned, so every consumer sees a consistent (x, y, `video_on`, sync) tuple in the same cycle.

Parameters:
- H_DISPLAY, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BP, 64, horizontal back porch (pixels); H_TOTAL = 1040
- V_DISPLAY, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = 666
- SYNC_POL, 1, active level of `hsync`/`vsync` (1 = active-high, as 800x600@72 requires)
- CLK_DIV, 2, `clk` cycles per pixel; 2 gives a 50 MHz pixel rate from 100 MHz; legal range 1..16

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- p_tick  out  1  pixel-enable strobe, one `clk` cycle wide, once every CLK_DIV cycles
- x  out  11  horizontal pixel count, 0..H_TOTAL-1
- y  out  11  vertical line count, 0..V_TOTAL-1
- video_on  out  1  high when x < H_DISPLAY and y < V_DISPLAY
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- frame_start  out  1  one-`clk` pulse coinciding with the update to (0,0)
- tick_1Hz  out  1  present only with VGA_BLINK_TICK_EN (see below)

Behaviour:
- Divider:
  - div counter runs 0..CLK_DIV-1 and wraps; p_tick = (div == CLK_DIV-1).
  - With CLK_DIV = 1, p_tick is constantly 1 after reset.
  - div resets to 0.
- Counters:
  - x and y update only on `clk` edges where p_tick = 1.
  - x increments each pixel. At H_TOTAL-1, x wraps to 0 and y increments.
  - y wraps to 0 after V_TOTAL-1, at the same edge as the x wrap.
- Decode:
  - `hsync`, `vsync`, `video_on` are computed from the next-state counts and registered on the same edge as x/y. They therefore always describe the x/y currently on the outputs; there is zero latency between coordinate and flags.
  - `hsync` is active when H_DISPLAY+H_FP <= x <= H_DISPLAY+H_FP+H_SYNC-1 (856..975 at defaults).
  - `vsync` is active when V_DISPLAY+V_FP <= y <= V_DISPLAY+V_FP+V_SYNC-1 (637..642 at defaults).
  - Active = SYNC_POL; inactive = ~SYNC_POL.
- frame_start:
  - Registered; high for exactly one `clk` cycle, on the edge where x/y become (0,0).
  - Low at all other times.
- Reset (asynchronous):
  - x = H_TOTAL-1, y = V_TOTAL-1, `video_on` = 0, `hsync` and `vsync` inactive, frame_start = 0, p_tick = 0, div = 0.
  - The first p_tick after release moves the outputs to (0,0), with `video_on` = 1 and frame_start = 1.
  - The outputs therefore never present an inconsistent tuple.
  - Reset asserted mid-frame takes effect immediately; no partial line or frame is completed.
- Width rules:
  - 11-bit counters. All comparisons are unsigned.
  - H_TOTAL and V_TOTAL must be <= 2048; an elaboration-time check flags violation.
- Downstream contract: a consumer with 1-cycle ROM latency sees stable x/y for CLK_DIV `clk` cycles per pixel, so CLK_DIV >= 2 covers a single ROM read.

Optional Feature:
- Macro: VGA_BLINK_TICK_EN.
- Defined:
  - Adds parameter FRAMES_PER_SEC, default 72, and output `tick_1Hz`.
  - A 7-bit frame counter increments on each frame_start and wraps at FRAMES_PER_SEC-1.
  - `tick_1Hz` pulses for one `clk` cycle, coincident with the frame_start that wraps the counter.
  - The frame counter resets to 0, so the first tick occurs on the 72nd frame_start after reset.
  - The counter and output are suitable for blinking colons in the clock display.
- Undefined: no frame counter, no `tick_1Hz` port; all other behaviour is identical.

Test Plan:
1. Reset release, CLK_DIV=2 -> p_tick every 2nd `clk`. The first p_tick gives x=0, y=0, `video_on`=1, frame_start=1, `hsync`=`vsync`=0.
2. Run one line -> `hsync`=1 exactly for x=856..975 (120 pixels, 240 `clk`). `video_on` falls at x=800. After x=1039, x=0 and y=1.
3. Run one full frame -> `vsync`=1 for y=637..642 only. The frame is 1040*666*2 = 1,385,280 `clk` between frame_start pulses, with no extra pulses in between.
4. Assert reset at x=500, y=300 -> outputs go immediately to x=1039, y=665, `video_on`=0, syncs inactive. Restart is as in scenario 1.
5. Override SYNC_POL=0, CLK_DIV=1 -> syncs idle 1 and pulse 0. p_tick is constantly 1. Sync windows match scenarios 2 and 3 with `clk` counts halved.
6. VGA_BLINK_TICK_EN defined, FRAMES_PER_SEC=3 -> `tick_1Hz` pulses with the 3rd, 6th, and 9th frame_start after reset, one `clk` wide each.
